lcd_bus_arbiter: RTL and testbench

- Shares the 8-bit HD44780-style LCD write bus (LCD, RS, RW, en) between two requesters: port 0 (init/command sequencer) and port 1 (text/LED status writer).
- Arbitrates, latches one byte per grant, and generates setup/enable/hold timing plus the post-command execution wait.
- Sits directly in front of the LCD pins inside LCD_top; the requesters never drive the pins.

---
 rtl/lcd_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-port arbiter for the HD44780 8-bit write bus with setup/enable/hold/exec-wait timing
//   clk           system clock
//   rstBt         synchronous active-high reset
//   req0/rs0/data0, ack0  port 0 request, register select, byte, one-cycle capture ack
//   req1/rs1/data1, ack1  port 1 request, register select, byte, one-cycle capture ack
//   LCD/RS/RW/en  LCD pins (RW tied low)
//   busy          transfer in progress
//   grant         owner of current or last transfer
//   Macro LCD_ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin
module lcd_bus_arbiter #(
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 25,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 4000,
  parameter int LONG_WAIT_CYC = 164000,
  parameter int CNT_W         = 18
) (
  input  logic       clk,
  input  logic       rstBt,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] LCD,
  output logic       RS,
  output logic       RW,
  output logic       en,
  output logic       busy,
  output logic       grant
);
  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, WAIT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] lcd_q, lcd_d;
  logic rs_q, rs_d, en_q, en_d, busy_q, busy_d, grant_q, grant_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic done, tie, win, long_wait;
`ifdef LCD_ARB_FIXED_PRIO_EN
  assign tie = 1'b0;
`else
  assign tie = ~grant_q;
`endif
  assign win = (req0 & req1) ? tie : req1;
  assign done = cnt_q == '0;
  // clear display (0x01) and return home (0x02) need the long execution wait
  assign long_wait = ~rs_q & (lcd_q == 8'h01 | lcd_q == 8'h02);
  always_comb begin
    state_d = state_q;
    cnt_d = done ? cnt_q : cnt_q - 1'b1;
    lcd_d = lcd_q;
    rs_d = rs_q;
    grant_d = grant_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    en_d = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = SETUP;
        cnt_d = CNT_W'(SETUP_CYC - 1);
        grant_d = win;
        rs_d = win ? rs1 : rs0;
        lcd_d = win ? data1 : data0;
        ack0_d = ~win;
        ack1_d = win;
      end
      SETUP: if (done) begin
        state_d = ENABLE;
        cnt_d = CNT_W'(EN_CYC - 1);
        en_d = 1'b1;
      end
      ENABLE: begin
        en_d = ~done;
        if (done) begin
          state_d = HOLD;
          cnt_d = CNT_W'(HOLD_CYC - 1);
        end
      end
      HOLD: if (done) begin
        state_d = WAIT;
        cnt_d = long_wait ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
      end
      WAIT: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rstBt) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lcd_q <= 8'h00;
      rs_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      grant_q <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lcd_q <= lcd_d;
      rs_q <= rs_d;
      en_q <= en_d;
      busy_q <= busy_d;
      grant_q <= grant_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
    end
  end
  assign LCD = lcd_q;
  assign RS = rs_q;
  assign RW = 1'b0;
  assign en = en_q;
  assign busy = busy_q;
  assign grant = grant_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed and randomized check of lcd_bus_arbiter against a transaction-timeline model
module tb_lcd_bus_arbiter;
  localparam int S = 2, E = 3, H = 1, W = 5, L = 20;
`ifdef LCD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] req, rs;
  logic [7:0] data [2];
  logic ack0, ack1, RS, RW, en, busy, grant;
  logic [7:0] LCD;
  lcd_bus_arbiter #(.SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .WAIT_CYC(W),
                    .LONG_WAIT_CYC(L), .CNT_W(18)) dut (
    .clk(clk), .rstBt(rst),
    .req0(req[0]), .rs0(rs[0]), .data0(data[0]), .ack0(ack0),
    .req1(req[1]), .rs1(rs[1]), .data1(data[1]), .ack1(ack1),
    .LCD(LCD), .RS(RS), .RW(RW), .en(en), .busy(busy), .grant(grant));
  int pass_cnt = 0, tot_cnt = 0;
  bit m_busy, m_grant, m_rs, m_en;
  bit [7:0] m_lcd;
  bit [1:0] m_ack;
  int m_k, m_tot;
  task automatic chk(string n, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  // model: a transfer is a timeline of m_tot cycles counted from the capture edge
  task automatic model_edge();
    bit w;
    m_ack = 2'b00;
    if (rst) begin
      m_busy = 0; m_k = 0; m_grant = 1; m_rs = 0; m_lcd = 8'h00;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        w = (req == 2'b11) ? (FIXED ? 1'b0 : !m_grant) : req[1];
        m_grant = w;
        m_rs = rs[w];
        m_lcd = data[w];
        m_tot = S + E + H + ((!m_rs && (m_lcd == 8'h01 || m_lcd == 8'h02)) ? L : W);
        m_k = 0;
        m_busy = 1;
        m_ack[w] = 1'b1;
      end
    end else begin
      m_k++;
      if (m_k == m_tot) m_busy = 0;
    end
    m_en = m_busy && m_k >= S && m_k < S + E;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ack0", ack0, m_ack[0]);
    chk("ack1", ack1, m_ack[1]);
    chk("en", en, m_en);
    chk("busy", busy, m_busy);
    chk("grant", grant, m_grant);
    chk("RS", RS, m_rs);
    chk("LCD", LCD, m_lcd);
    chk("RW", RW, 0);
  endtask
  task automatic measure(output int nb, output int ne, output int fe);
    nb = 0; ne = 0; fe = -1;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      nb++;
      if (en) begin
        if (fe < 0) fe = i;
        ne++;
      end
      step();
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) step();
    chk("idle_timeout", busy, 0);
  endtask
  task automatic wait_en();
    for (int i = 0; i < 10 && !en; i++) step();
    chk("en_timeout", en, 1);
  endtask
  task automatic new_byte(int p);
    rs[p] = 1'($urandom);
    data[p] = ($urandom % 4 == 0) ? 8'(1 + $urandom % 2) : 8'($urandom);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int nb, ne, fe, who, n;
    rst = 1; req = 0; rs = 0; data[0] = 0; data[1] = 0;
    step(); step();
    chk("rst_grant", grant, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lcd", LCD, 0);
    chk("rst_en", en, 0);
    rst = 0;
    req[1] = 1; rs[1] = 1; data[1] = 8'h41;
    step();
    req[1] = 0;
    chk("sw_ack1", ack1, 1);
    chk("sw_lcd", LCD, 8'h41);
    chk("sw_rs", RS, 1);
    chk("sw_grant", grant, 1);
    measure(nb, ne, fe);
    chk("sw_busy_len", nb, 11);
    chk("sw_en_len", ne, 3);
    chk("sw_en_start", fe, 2);
    req[0] = 1; rs[0] = 0; data[0] = 8'h01;
    step();
    req[0] = 0;
    chk("clr_ack0", ack0, 1);
    measure(nb, ne, fe);
    chk("clr_busy_len", nb, 26);
    chk("clr_en_len", ne, 3);
    rst = 1; step(); rst = 0;
    req = 2'b11; rs = 2'b11; data[0] = 8'h30; data[1] = 8'h31;
    for (int t = 0; t < 4; t++) begin
      who = 2;
      for (int i = 0; i < 40; i++) begin
        step();
        if (ack0) begin who = 0; break; end
        if (ack1) begin who = 1; break; end
      end
      chk("tie_order", who, FIXED ? 0 : t % 2);
    end
    req = 0;
    wait_idle();
    req[1] = 1; rs[1] = 1; data[1] = 8'h42;
    step();
    req[1] = 0;
    wait_en();
    req[0] = 1; rs[0] = 1; data[0] = 8'h33;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (ack0) break;
    end
    req[0] = 0;
    chk("busy_req_latency", n, 10);
    chk("busy_req_lcd", LCD, 8'h33);
    wait_idle();
    req[1] = 1; rs[1] = 1; data[1] = 8'h55;
    step();
    req[1] = 0;
    wait_en();
    step();
    chk("rst_mid_en2", en, 1);
    rst = 1; step(); rst = 0;
    chk("rst_mid_en", en, 0);
    chk("rst_mid_lcd", LCD, 0);
    chk("rst_mid_rs", RS, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", {ack1, ack0}, 0);
    req[0] = 1; rs[0] = 1; data[0] = 8'h66;
    step();
    req[0] = 0;
    chk("post_rst_ack0", ack0, 1);
    chk("post_rst_lcd", LCD, 8'h66);
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 400 == 0);
      for (int p = 0; p < 2; p++) begin
        if (req[p] && m_ack[p]) begin
          if ($urandom % 2 == 1) req[p] = 0;
          else new_byte(p);
        end else if (!req[p]) begin
          if ($urandom % 5 == 0) begin
            req[p] = 1;
            new_byte(p);
          end else data[p] = 8'($urandom);
        end
      end
      step();
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
